// File: rtl/mips_mem_responder_if.sv
// Core bus and loader byte stream for mips_mem_responder.
// Mem_Bus stays a plain inout port so tri-state resolution remains simple.
interface mips_mem_responder_if;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_DATA;
  logic        LD_LAST;
  logic        LD_READY;

  modport master (
    output CS, WE, ADDR,
    output LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  LD_READY
  );

  modport slave (
    input  CS, WE, ADDR,
    input  LD_START, LD_VALID, LD_DATA, LD_LAST,
    output LD_READY
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified word memory for the multi-cycle MIPS core.
// Zero-wait reads, synchronous writes, byte-stream loader.
module mips_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               CLK,
  input  logic               RST,
  mips_mem_responder_if.slave bus,
  inout  wire  [31:0]        Mem_Bus,
  output logic               CPU_HOLD,
  output logic [AW:0]        LD_COUNT,
  output logic               ERR
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        last_q, last_d;
  logic [AW:0] ld_addr_q, ld_addr_d;
  logic [AW:0] ld_count_q, ld_count_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          in_range;
  logic [AW-1:0] idx;
  logic          ld_full;
  logic          core_rd;
  logic          core_wr;
  logic          ld_wr;
  logic [31:0]   rd_data;

  assign in_range = bus.ADDR < 32'(DEPTH);
  assign idx      = bus.ADDR[AW-1:0];
  assign ld_full  = ld_addr_q == (AW+1)'(DEPTH);

  // Drive the shared bus only for an idle-state core read.
  assign Mem_Bus = core_rd ? rd_data : 32'bz;

  // State register; array contents survive reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      last_q     <= 1'b0;
      ld_addr_q  <= '0;
      ld_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      last_q     <= last_d;
      ld_addr_q  <= ld_addr_d;
      ld_count_q <= ld_count_d;
      err_q      <= err_d;
    end
  end

  // Array write port: core write in IDLE or loader commit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (core_wr)
        mem[idx] <= Mem_Bus;
      else if (ld_wr)
        mem[ld_addr_q[AW-1:0]] <= asm_q;
    end
  end

  // Next-state and loader datapath.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    last_d     = last_q;
    ld_addr_d  = ld_addr_q;
    ld_count_d = ld_count_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.CS && !in_range)
          err_d = 1'b1;
        if (bus.LD_START) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          asm_d      = '0;
          last_d     = 1'b0;
          ld_addr_d  = '0;
          ld_count_d = '0;
          err_d      = 1'b0;
        end
      end
      LOAD: begin
        if (bus.LD_VALID) begin
          asm_d[8*byte_cnt_q +: 8] = bus.LD_DATA;
          byte_cnt_d = byte_cnt_q + 2'd1;
          last_d     = bus.LD_LAST;
          if (byte_cnt_q == 2'd3 || bus.LD_LAST)
            state_d = COMMIT;
        end
      end
      COMMIT: begin
        byte_cnt_d = '0;
        asm_d      = '0;
        if (ld_full) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ld_addr_d  = ld_addr_q + 1'b1;
          ld_count_d = ld_count_q + 1'b1;
          state_d    = last_q ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and access decode.
  always_comb begin
    core_rd      = (state_q == IDLE) && bus.CS && !bus.WE;
    core_wr      = (state_q == IDLE) && bus.CS && bus.WE && in_range;
    ld_wr        = (state_q == COMMIT) && !ld_full;
    rd_data      = in_range ? mem[idx] : 32'h0;
    bus.LD_READY = (state_q == LOAD);
    CPU_HOLD     = (state_q != IDLE);
    LD_COUNT     = ld_count_q;
    ERR          = err_q;
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder.
// Checks core access, tri-state, loader and range errors.
module tb_mips_mem_responder;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mips_mem_responder_if b ();
  mips_mem_responder_if b4 ();

  wire  [31:0] mbus;
  wire  [31:0] mbus4;
  logic        tb_en;
  logic [31:0] tb_d;

  assign mbus  = tb_en ? tb_d : 32'bz;
  assign mbus4 = 32'bz;

  logic        hold, err;
  logic [10:0] cnt;
  logic        hold4, err4;
  logic [2:0]  cnt4;

  mips_mem_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (b),
    .Mem_Bus  (mbus),
    .CPU_HOLD (hold),
    .LD_COUNT (cnt),
    .ERR      (err)
  );

  mips_mem_responder #(.DEPTH(4), .AW(2)) dut4 (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (b4),
    .Mem_Bus  (mbus4),
    .CPU_HOLD (hold4),
    .LD_COUNT (cnt4),
    .ERR      (err4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string tag);
    b.CS = 1'b1; b.WE = 1'b0; b.ADDR = a;
    @(negedge CLK);
    chk(tag, mbus, exp);
    tick();
    b.CS = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    tb_en = 1'b0; tb_d = '0;
    b.CS = 0; b.WE = 0; b.ADDR = 0;
    b.LD_START = 0; b.LD_VALID = 0;
    b.LD_DATA = 0; b.LD_LAST = 0;
    b4.CS = 0; b4.WE = 0; b4.ADDR = 0;
    b4.LD_START = 0; b4.LD_VALID = 0;
    b4.LD_DATA = 0; b4.LD_LAST = 0;
    tick();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(b.LD_READY), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_err", 32'(err), 0);
    tick();

    // write then read
    b.CS = 1; b.WE = 1; b.ADDR = 5;
    tb_en = 1; tb_d = 32'hDEADBEEF;
    tick();
    tb_en = 0; b.WE = 0;
    @(negedge CLK);
    chk("wr_rd", mbus, 32'hDEADBEEF);
    chk("wr_rd_err", 32'(err), 0);
    tick();

    // tri-state: DUT must not add its data to ours
    b.CS = 0; b.ADDR = 5;
    tb_en = 1; tb_d = 32'h0;
    @(negedge CLK);
    chk("z_cs0", mbus, 32'h0);
    tick();
    b.CS = 1; b.WE = 1;
    @(negedge CLK);
    chk("z_we1", mbus, 32'h0);
    tick();
    tb_en = 0; b.CS = 0; b.WE = 0;
    rd(5, 32'h0, "rd_after_wr0");

    // full-word load
    b.LD_START = 1;
    tick();
    b.LD_START = 0;
    b.LD_VALID = 1;
    for (int i = 0; i < 8; i++) begin
      b.LD_DATA = 8'(i + 1);
      b.LD_LAST = (i == 7);
      @(negedge CLK);
      chk($sformatf("ld_ready_%0d", i), 32'(b.LD_READY), 1);
      chk($sformatf("ld_hold_%0d", i), 32'(hold), 1);
      tick();
      if (i == 3 || i == 7) begin
        @(negedge CLK);
        chk($sformatf("cm_ready_%0d", i), 32'(b.LD_READY), 0);
        chk($sformatf("cm_hold_%0d", i), 32'(hold), 1);
        tick();
      end
    end
    b.LD_VALID = 0; b.LD_LAST = 0;
    @(negedge CLK);
    chk("full_hold_off", 32'(hold), 0);
    chk("full_ready_off", 32'(b.LD_READY), 0);
    chk("full_count", 32'(cnt), 2);
    tick();
    rd(0, 32'h04030201, "full_m0");
    rd(1, 32'h08070605, "full_m1");
    chk("full_err", 32'(err), 0);

    // short final word
    b.LD_START = 1;
    tick();
    b.LD_START = 0;
    b.LD_VALID = 1;
    b.LD_DATA = 8'hAA; tick();
    b.LD_DATA = 8'hBB; tick();
    b.LD_DATA = 8'hCC; b.LD_LAST = 1; tick();
    b.LD_VALID = 0; b.LD_LAST = 0;
    @(negedge CLK);
    chk("short_commit_hold", 32'(hold), 1);
    tick();
    @(negedge CLK);
    chk("short_hold_off", 32'(hold), 0);
    chk("short_count", 32'(cnt), 1);
    tick();
    rd(0, 32'h00CCBBAA, "short_m0");
    rd(1, 32'h08070605, "short_m1");

    // reset mid-load after 6 bytes
    b.LD_START = 1;
    tick();
    b.LD_START = 0;
    b.LD_VALID = 1;
    for (int i = 0; i < 6; i++) begin
      b.LD_DATA = 8'((i + 1) * 16);
      tick();
      if (i == 3) tick();
    end
    b.LD_VALID = 0;
    @(negedge CLK);
    chk("mid_hold", 32'(hold), 1);
    RST = 1;
    tick();
    RST = 0;
    @(negedge CLK);
    chk("rstl_hold", 32'(hold), 0);
    chk("rstl_ready", 32'(b.LD_READY), 0);
    chk("rstl_count", 32'(cnt), 0);
    tick();
    rd(0, 32'h40302010, "rstl_m0");
    rd(1, 32'h08070605, "rstl_m1");

    // DEPTH=4: out-of-range read
    b4.CS = 1; b4.WE = 0; b4.ADDR = 4;
    @(negedge CLK);
    chk("oor_rd_bus", mbus4, 32'h0);
    tick();
    b4.CS = 0;
    @(negedge CLK);
    chk("oor_rd_err", 32'(err4), 1);
    tick();

    // DEPTH=4: load 5 words
    b4.LD_START = 1;
    tick();
    b4.LD_START = 0;
    @(negedge CLK);
    chk("ovf_err_clr", 32'(err4), 0);
    b4.LD_VALID = 1;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        b4.LD_DATA = 8'(w * 4 + k + 1);
        b4.LD_LAST = (w == 4 && k == 3);
        tick();
      end
      tick();
    end
    b4.LD_VALID = 0; b4.LD_LAST = 0;
    @(negedge CLK);
    chk("ovf_count", 32'(cnt4), 4);
    chk("ovf_err", 32'(err4), 1);
    chk("ovf_hold", 32'(hold4), 0);
    tick();
    b4.CS = 1; b4.WE = 0; b4.ADDR = 3;
    @(negedge CLK);
    chk("ovf_m3", mbus4, 32'h100F0E0D);
    tick();
    b4.ADDR = 0;
    @(negedge CLK);
    chk("ovf_m0", mbus4, 32'h04030201);
    tick();
    b4.CS = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Word-addressed unified instruction/data memory that answers the multi-cycle MIPS core's CS/WE/ADDR/Mem_Bus initiator interface.
- Provides zero-wait-state combinational reads and synchronous writes.
- Includes a byte-stream program loader that fills memory while it holds the core in reset through CPU_HOLD.
- Sits between the core and the board-level loader (UART/testbench byte source).

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- AW, 10, index width; DEPTH must be at most 2**AW.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CS  input  1  core chip select.
- WE  input  1  core write enable; only meaningful with CS=1.
- ADDR  input  32  core word address.
- Mem_Bus  inout  32  shared data bus; the core drives it on writes, this block drives it on reads.
- LD_START  input  1  single-cycle pulse that begins a load at word 0.
- LD_VALID  input  1  loader byte valid.
- LD_DATA  input  8  loader byte.
- LD_LAST  input  1  marks the final byte of the image; qualified by LD_VALID.
- LD_READY  output  1  block accepts a byte this cycle.
- CPU_HOLD  output  1  OR into the core's RST while loading.
- LD_COUNT  output  AW+1  words committed in the current or last load.
- ERR  output  1  sticky error flag.

Behaviour:
- Reset: state IDLE, LD_READY=0, CPU_HOLD=0, LD_COUNT=0, ERR=0, byte counter=0, assembly register=0, Mem_Bus tri-stated. Array contents are NOT cleared.
- Reset mid-load aborts the load. Words already committed remain, and CPU_HOLD is 0 from the cycle after the reset edge.
- In range means ADDR < DEPTH; the low AW bits of ADDR index the array.
- Core read (state IDLE, CS=1, WE=0):
  - Mem_Bus = mem[ADDR] combinationally, in the same cycle, so the core latches it at that cycle's edge.
  - An out-of-range read drives 32'h0 and sets ERR.
- Core write (state IDLE, CS=1, WE=1):
  - Mem_Bus stays tri-stated.
  - mem[ADDR] <= Mem_Bus at the rising edge.
  - An out-of-range write is dropped and sets ERR.
- Mem_Bus is tri-stated whenever CS=0, WE=1, or state is not IDLE. This block never drives while WE=1.
- Loader FSM states: IDLE, LOAD, COMMIT.
  - IDLE:
    - LD_START=1 -> LOAD.
    - On entry: load address=0, byte counter=0, assembly register=0, LD_COUNT=0, ERR=0.
  - LOAD:
    - LD_READY=1, CPU_HOLD=1.
    - Byte accepted when LD_VALID=1; stored little-endian: byte k goes to bits [8k+7:8k], k=0..3.
    - After the 4th byte, or any byte with LD_LAST=1 -> COMMIT.
    - Unfilled bytes of a short final word are 0.
    - LD_LAST is latched into a last flag.
  - COMMIT (exactly 1 cycle):
    - LD_READY=0, CPU_HOLD=1.
    - mem[load address] <= assembled word; load address++, LD_COUNT++.
    - Byte counter and assembly register cleared.
    - Next state: IDLE if the last flag is set, else LOAD.
    - If load address = DEPTH: the write is dropped, ERR=1, LD_COUNT is not incremented, next state IDLE.
- Simultaneous events:
  - LD_START outside IDLE is ignored.
  - Core CS/WE activity outside IDLE is ignored: no write, no read drive.
  - A LD_START pulse in the same cycle as a core access in IDLE: the core access completes that cycle and the FSM enters LOAD at the edge.
- Load-to-run latency: the last byte is accepted at edge N; COMMIT occupies cycle N+1; CPU_HOLD=0 from cycle N+2.
- ERR is sticky until RST or the next LD_START.

Test Plan:
- Write then read:
  - Stimulus: IDLE; drive CS=1, WE=1, ADDR=5, Mem_Bus=32'hDEADBEEF for one cycle; then CS=1, WE=0, ADDR=5.
  - Required response: Mem_Bus=32'hDEADBEEF in the same cycle; ERR=0.
- Tri-state check:
  - Stimulus: CS=0, and separately CS=1 with WE=1.
  - Required response: the block presents Z on all 32 bits of Mem_Bus.
- Full-word load:
  - Stimulus: LD_START, then bytes 01,02,03,04,05,06,07,08 with LD_LAST on 08; LD_VALID held high throughout.
  - Required response: mem[0]=32'h04030201, mem[1]=32'h08070605, LD_COUNT=2, LD_READY=0 in each COMMIT cycle, CPU_HOLD high from LOAD entry to two cycles after the final byte.
- Short final word:
  - Stimulus: LD_START, bytes AA, BB, CC with LD_LAST on CC.
  - Required response: mem[0]=32'h00CCBBAA, LD_COUNT=1, FSM returns to IDLE.
- Out of range:
  - Stimulus: with DEPTH=4, a core read at ADDR=4.
  - Required response: Mem_Bus=0, ERR=1.
  - Stimulus: with DEPTH=4, load 5 words.
  - Required response: the 5th word is dropped, LD_COUNT=4, ERR=1.
- Reset mid-load:
  - Stimulus: RST after 6 bytes.
  - Required response: mem[0] holds the first word, mem[1] is unchanged, CPU_HOLD=0 and LD_READY=0 from the next cycle, core reads work normally.
